// File: rtl/bcd_count_ctrl_if.sv
// Command and status bundle between a controlling top level and bcd_count_ctrl.
interface bcd_count_ctrl_if #(
   parameter int DIGITS = 4
);
   logic                  START;
   logic                  STOP;
   logic                  CLEAR;
   logic                  LOAD;
   logic                  DIR;
   logic [4*DIGITS-1:0]   LOAD_VAL;
   logic [4*DIGITS-1:0]   LIMIT;
   logic [4*DIGITS-1:0]   COUNT;
   logic [1:0]            STATE;
   logic                  BUSY;
   logic                  TICK;
   logic                  DONE_P;

   modport master (
      output START, STOP, CLEAR, LOAD, DIR, LOAD_VAL, LIMIT,
      input  COUNT, STATE, BUSY, TICK, DONE_P
   );

   modport slave (
      input  START, STOP, CLEAR, LOAD, DIR, LOAD_VAL, LIMIT,
      output COUNT, STATE, BUSY, TICK, DONE_P
   );
endinterface

// File: rtl/bcd_count_ctrl.sv
// Sequencing controller for a cascaded multi-digit BCD count.
// Owns the digit registers, steps them up or down every PRESCALE clocks
// while running, and flags the terminal value. All state moves on the
// falling clock edge; reset is asynchronous and active-low.
module bcd_count_ctrl #(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 1
) (
   input logic             CLK,
   input logic             RES,
   bcd_count_ctrl_if.slave bus
);
   localparam int          W        = 4 * DIGITS;
   localparam int unsigned ND       = DIGITS;
   localparam int          PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    count_q, count_d;
   logic [PW-1:0]   psc_q, psc_d;
   logic            tick_q, tick_d;
   logic            donep_q, donep_d;

   logic [W-1:0]    count_inc;
   logic [W-1:0]    count_dec;
   logic [W-1:0]    load_sat;
   logic            count_zero;

   // Ripple BCD increment; an all-9s value wraps to all-0s.
   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         carry;
      r     = v;
      carry = 1'b1;
      for (int unsigned i = 0; i < ND; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Ripple BCD decrement; only used when the count is nonzero.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int unsigned i = 0; i < ND; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Non-decimal preset digits are clamped to 9 so the count stays valid BCD.
   function automatic logic [W-1:0] bcd_sat(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int unsigned i = 0; i < ND; i++) begin
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
      end
      return r;
   endfunction

   // Step candidates and preset value derived from the current registers.
   always_comb begin
      count_inc  = bcd_inc(count_q);
      count_dec  = bcd_dec(count_q);
      load_sat   = bcd_sat(bus.LOAD_VAL);
      count_zero = (count_q == '0);
   end

   // Command decode (CLEAR > LOAD > STOP > START), prescaler and stepping.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      psc_d   = psc_q;
      tick_d  = 1'b0;
      donep_d = 1'b0;
      if (bus.CLEAR) begin
         count_d = '0;
         psc_d   = '0;
         state_d = ST_IDLE;
      end else if (bus.LOAD && (state_q != ST_RUN)) begin
         count_d = load_sat;
         state_d = ST_IDLE;
      end else if (bus.STOP) begin
         if (state_q == ST_RUN) state_d = ST_PAUSE;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_PAUSE: begin
               if (bus.START) begin
                  if (bus.DIR && count_zero) begin
                     state_d = ST_DONE;
                     donep_d = 1'b1;
                  end else begin
                     state_d = ST_RUN;
                     if (state_q == ST_IDLE) psc_d = '0;
                  end
               end
            end
            ST_RUN: begin
               if (psc_q == PSC_LAST) begin
                  psc_d = '0;
                  if (!bus.DIR) begin
                     count_d = count_inc;
                     tick_d  = 1'b1;
                     if (count_inc == bus.LIMIT) begin
                        state_d = ST_DONE;
                        donep_d = 1'b1;
                     end
                  end else if (count_zero) begin
                     // Already at zero when counting down: terminate without stepping.
                     state_d = ST_DONE;
                     donep_d = 1'b1;
                  end else begin
                     count_d = count_dec;
                     tick_d  = 1'b1;
                     if (count_dec == '0) begin
                        state_d = ST_DONE;
                        donep_d = 1'b1;
                     end
                  end
               end else begin
                  psc_d = psc_q + PW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // State and output registers, falling-edge clocked with async clear.
   always_ff @(negedge CLK or negedge RES) begin
      if (!RES) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         psc_q   <= '0;
         tick_q  <= 1'b0;
         donep_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         psc_q   <= psc_d;
         tick_q  <= tick_d;
         donep_q <= donep_d;
      end
   end

   assign bus.COUNT  = count_q;
   assign bus.STATE  = state_q;
   assign bus.BUSY   = (state_q == ST_RUN);
   assign bus.TICK   = tick_q;
   assign bus.DONE_P = donep_q;
endmodule

// File: doc/bcd_count_ctrl.md
# bcd_count_ctrl

Sequencing controller for a cascaded multi-digit BCD count. It owns the digit registers and runs them up or down at a programmable prescaled rate. It accepts start/stop/clear/load commands and signals when a terminal value is reached. It is the control layer that a display or stopwatch top level instantiates in place of free-running BCD counters.

## Interface

Parameters:
- DIGITS, 4: number of BCD digits; count width is 4*DIGITS.
- PRESCALE, 1: CLK edges per count step (≥1).

Ports:
- CLK  input  1  clock; all state changes on the falling edge.
- RES  input  1  reset, asynchronous, active-low.
- START  input  1  begin/resume counting (level sampled each edge).
- STOP  input  1  pause counting.
- CLEAR  input  1  zero count, return to IDLE.
- LOAD  input  1  load LOAD_VAL into count.
- DIR  input  1  0 = count up, 1 = count down; sampled each step.
- LOAD_VAL  input  4*DIGITS  preset value, digit 0 in bits [3:0].
- LIMIT  input  4*DIGITS  terminal value for up mode.
- COUNT  output  4*DIGITS  current BCD count.
- STATE  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
- BUSY  output  1  high in RUN.
- TICK  output  1  one-cycle pulse on each count step.
- DONE_P  output  1  one-cycle pulse on entry to DONE.

## Operation

- Reset (RES low, async): COUNT=0, STATE=IDLE, prescaler=0, BUSY=TICK=DONE_P=0.
- Command priority per edge is CLEAR > LOAD > STOP > START. Only the highest asserted command acts.
- CLEAR, any state: COUNT=0, prescaler=0, → IDLE.
- LOAD, in IDLE/PAUSE/DONE: COUNT=LOAD_VAL, → IDLE. Any LOAD_VAL digit >9 is stored as 9. LOAD in RUN is ignored.
- IDLE: START → RUN, prescaler cleared.
- RUN:
  - STOP → PAUSE; prescaler is held.
  - Otherwise the prescaler increments. When it reaches PRESCALE-1, it wraps to 0 and a step occurs.
- PAUSE: START → RUN, prescaler resumes from its held value.
- Step, up mode: BCD increment with digit carry (9→0 carries). An all-9s count wraps to all-0s.
- Step, down mode: BCD decrement with borrow (0→9 borrows). The count never steps below 0.
- Terminal detection:
  - Up mode: after a step, COUNT==LIMIT → DONE, DONE_P.
  - Down mode: after a step, COUNT==0 → DONE, DONE_P.
  - Down mode, START issued while COUNT==0: → DONE directly with DONE_P, no step.
- DONE: count held. START and STOP are ignored; only CLEAR or LOAD leave DONE.
- LIMIT with a digit >9 is never matched; the count wraps indefinitely.

## Timing

- START sampled at edge N → STATE=RUN after N. The first step is at edge N+PRESCALE; COUNT and TICK update at that edge.
- TICK is high for exactly the cycle after each step edge. DONE_P coincides with the TICK of the terminal step.
- STOP and a step due on the same edge: STOP wins, no step, and the prescaler does not advance.
- RUN → PAUSE → RUN preserves prescaler phase. Total steps equal RUN cycles / PRESCALE.
- DIR change mid-run takes effect on the next step; no restart.
- RES asserted mid-step: async clear wins immediately, with no partial count.
- Outputs are registered. STATE and BUSY change on the same edge as the command.

## Test plan

- Reset, then START with DIGITS=4, PRESCALE=1, DIR=0, LIMIT=0012 → COUNT 0001…0012 on consecutive edges; DONE_P on the 0012 edge; STATE=11; further STARTs do not change COUNT.
- LOAD 0100, DIR=1, PRESCALE=3, START → COUNT 0099 three edges later (borrow across two digits); steps every 3 edges; reaches 0000 → DONE_P.
- PRESCALE=4, run 6 cycles, STOP for 5 cycles, START → next step exactly 2 RUN cycles after resume; STOP on a step edge produces no TICK.
- LOAD 9999, LIMIT=0003, up → 0000 (wrap), 0001…0003 → DONE; LOAD_VAL 00A5 → COUNT 0095.
- CLEAR+LOAD+START on the same edge in RUN → COUNT=0000, IDLE. LOAD in RUN is ignored. DIR=1 with COUNT=0000, START → DONE_P next edge, COUNT unchanged.
- RES pulsed low mid-RUN between edges → outputs zero immediately; STATE=IDLE; no TICK after release until START.
